// File: rtl/score_keeper_if.sv
// Score engine signal bundle: game control and collision inputs, score outputs.
// Latency: none; this file only groups the wires.
// Backpressure: none; every signal is a level or a single-cycle pulse.
interface score_keeper_if #(
  parameter int SCORE_W = 10
);
  logic               game_start;
  logic               active;
  logic               collision;
  logic [1:0]         color;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic [2:0]         combo;
  logic               new_high;

  // Game controller and collision logic side.
  modport master (
    output game_start, active, collision, color,
    input  score, high_score, combo, new_high
  );

  // Score engine side.
  modport slave (
    input  game_start, active, collision, color,
    output score, high_score, combo, new_high
  );
endinterface

// File: rtl/score_keeper.sv
// Scores collision rising edges by colour, using a combo multiplier, a saturating score and a kept high score.
// Latency: an event sampled at one posedge is visible on all outputs right after that edge (1 cycle).
// Backpressure: none; a held collision level scores once, so there is at most one event every 2 cycles.
module score_keeper #(
  parameter int SCORE_W   = 10,
  parameter int PTS_GREEN = 2,
  parameter int PTS_BLUE  = 5,
  parameter int PEN_RED   = 3,
  parameter int COMBO_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  score_keeper_if.slave sk
);
  localparam int SUM_W = SCORE_W + 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SUM_W-1:0]   GREEN_W   = (SUM_W)'(PTS_GREEN);
  localparam logic [SUM_W-1:0]   BLUE_W    = (SUM_W)'(PTS_BLUE);
  localparam logic [SCORE_W-1:0] RED_W     = (SCORE_W)'(PEN_RED);
  localparam logic [2:0]         CMAX3     = 3'(COMBO_MAX);
  localparam logic [3:0]         CMAX4     = 4'(COMBO_MAX);

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [2:0]         combo_q, combo_d;
  logic               new_high_q, new_high_d;
  logic               coll_q;

  logic               event_hit;
  logic [3:0]         combo_inc;
  logic [3:0]         mult;
  logic [SUM_W-1:0]   base;
  logic [SUM_W-1:0]   sum;
  logic [2:0]         combo_next_good;

  // Score a rising edge of collision only while the game runs; the multiplier comes from the combo held before this update.
  always_comb begin
    event_hit       = sk.collision & ~coll_q & sk.active;
    combo_inc       = {1'b0, combo_q} + 4'd1;
    mult            = (combo_inc > CMAX4) ? CMAX4 : combo_inc;
    base            = (sk.color == 2'b10) ? BLUE_W : GREEN_W;
    sum             = {4'b0, score_q} + base * {{SCORE_W{1'b0}}, mult};
    combo_next_good = (combo_q >= CMAX3) ? CMAX3 : combo_q + 3'd1;

    score_d    = score_q;
    combo_d    = combo_q;
    high_d     = high_q;
    new_high_d = 1'b0;

    if (sk.game_start) begin
      // A new game drops any coincident event; the high score survives.
      score_d = '0;
      combo_d = '0;
    end else if (event_hit) begin
      unique case (sk.color)
        2'b01, 2'b10: begin
          score_d = (sum > {4'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
          combo_d = combo_next_good;
        end
        2'b11: begin
          score_d = (score_q >= RED_W) ? score_q - RED_W : '0;
          combo_d = '0;
        end
        default: ;
      endcase
      if (score_d > high_q) begin
        high_d     = score_d;
        new_high_d = 1'b1;
      end
    end
  end

  // State registers; the edge detector tracks collision even while the game is paused.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q    <= '0;
      high_q     <= '0;
      combo_q    <= '0;
      new_high_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      score_q    <= score_d;
      high_q     <= high_d;
      combo_q    <= combo_d;
      new_high_q <= new_high_d;
      coll_q     <= sk.collision;
    end
  end

  assign sk.score      = score_q;
  assign sk.high_score = high_q;
  assign sk.combo      = combo_q;
  assign sk.new_high   = new_high_q;
endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed checks of score_keeper against a behavioural scoring model.
// Latency: the model is updated and compared 1 ns after each posedge.
// Backpressure: none; inputs change on negedges.
module tb_score_keeper;
  localparam int SW   = 10;
  localparam int PG   = 2;
  localparam int PB   = 5;
  localparam int PR   = 3;
  localparam int CM   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_keeper_if #(.SCORE_W(SW)) sif ();

  score_keeper #(
    .SCORE_W(SW), .PTS_GREEN(PG), .PTS_BLUE(PB), .PEN_RED(PR), .COMBO_MAX(CM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sk (sif.slave)
  );

  int errs   = 0;
  int checks = 0;

  // Reference state, kept as plain integers.
  int m_score, m_high, m_combo, m_nh;
  bit m_coll;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model and compare all four outputs.
  task automatic step(input bit r, input bit gs, input bit act, input bit coll,
                      input logic [1:0] col, input string tag);
    int mult, s;
    bit ev;
    @(negedge clk);
    rst            = r;
    sif.game_start = gs;
    sif.active     = act;
    sif.collision  = coll;
    sif.color      = col;
    @(posedge clk);
    #1;
    if (r) begin
      m_score = 0; m_high = 0; m_combo = 0; m_nh = 0; m_coll = 0;
    end else begin
      ev = coll && !m_coll && act;
      m_nh = 0;
      if (gs) begin
        m_score = 0;
        m_combo = 0;
      end else if (ev) begin
        mult = (m_combo + 1 < CM) ? m_combo + 1 : CM;
        s = m_score;
        case (col)
          2'b01: s = m_score + PG * mult;
          2'b10: s = m_score + PB * mult;
          2'b11: s = (m_score >= PR) ? m_score - PR : 0;
          default: s = m_score;
        endcase
        if (s > SMAX) s = SMAX;
        if (col == 2'b11) m_combo = 0;
        else if (col != 2'b00) m_combo = (m_combo + 1 < CM) ? m_combo + 1 : CM;
        if (s > m_high) begin
          m_high = s;
          m_nh   = 1;
        end
        m_score = s;
      end
      m_coll = coll;
    end
    chk({tag, ".score"}, int'(sif.score), m_score);
    chk({tag, ".high"},  int'(sif.high_score), m_high);
    chk({tag, ".combo"}, int'(sif.combo), m_combo);
    chk({tag, ".nh"},    int'(sif.new_high), m_nh);
  endtask

  // One event followed by a release cycle.
  task automatic hit(input logic [1:0] col, input string tag);
    step(0, 0, 1, 1, col, tag);
    step(0, 0, 1, 0, col, {tag, "_rel"});
  endtask

  initial begin
    logic [1:0] cols [3];
    int exp_s [3];
    int exp_c [3];
    cols  = '{2'b01, 2'b01, 2'b10};
    exp_s = '{2, 6, 21};
    exp_c = '{1, 2, 3};

    rst = 1'b1;
    sif.game_start = 1'b0;
    sif.active     = 1'b0;
    sif.collision  = 1'b0;
    sif.color      = 2'b00;

    // Reset for two cycles, then idle.
    step(1, 0, 0, 0, 2'b00, "rst0");
    step(1, 0, 0, 0, 2'b00, "rst1");
    step(0, 0, 0, 0, 2'b00, "idle");
    chk("reset_score", int'(sif.score), 0);
    chk("reset_high",  int'(sif.high_score), 0);

    // G, G, B: multiplier grows with the combo.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, cols[i], "ggb");
      chk($sformatf("ggb%0d_score", i), int'(sif.score), exp_s[i]);
      chk($sformatf("ggb%0d_combo", i), int'(sif.combo), exp_c[i]);
      chk($sformatf("ggb%0d_nh", i),    int'(sif.new_high), 1);
      step(0, 0, 1, 0, 2'b00, "ggb_rel");
    end
    chk("ggb_high", int'(sif.high_score), 21);

    // Red penalty: combo resets, no high pulse.
    step(0, 0, 1, 1, 2'b11, "red");
    chk("red_score", int'(sif.score), 18);
    chk("red_nh",    int'(sif.new_high), 0);
    step(0, 0, 1, 0, 2'b00, "red_rel");

    // game_start coinciding with a collision edge wins.
    step(0, 1, 1, 1, 2'b10, "gs_coll");
    chk("gs_score", int'(sif.score), 0);
    chk("gs_high",  int'(sif.high_score), 21);
    step(0, 0, 1, 0, 2'b00, "gs_rel");

    // Red penalty floors at zero.
    hit(2'b01, "g_two");
    chk("two_score", int'(sif.score), 2);
    hit(2'b11, "red_floor");
    chk("floor_score", int'(sif.score), 0);

    // Held collision level scores exactly once.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 1, 2'b10, "hold");
    step(0, 0, 1, 0, 2'b00, "hold_rel");
    chk("hold_score", int'(sif.score), 5);

    // Toggling while paused changes nothing.
    for (int i = 0; i < 8; i++) step(0, 0, 0, i[0], 2'b01, "paused");
    chk("paused_score", int'(sif.score), 5);
    step(0, 0, 1, 0, 2'b00, "resume");

    // Saturation at the top of the score range.
    for (int i = 0; i < 60; i++) hit(2'b10, "sat");
    chk("sat_score", int'(sif.score), SMAX);
    hit(2'b10, "sat_more");
    chk("sat_hold", int'(sif.score), SMAX);
    chk("sat_high", int'(sif.high_score), SMAX);

    // Reset in mid-game clears everything.
    step(1, 0, 1, 1, 2'b01, "rst_mid");
    chk("rstmid_score", int'(sif.score), 0);
    chk("rstmid_high",  int'(sif.high_score), 0);

    // Randomised play.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 85, 1'($urandom), 2'($urandom), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
